// File: rtl/ahb_busreq_pkg.sv
// ---------------------------------------------------------------------------
// ahb_busreq_pkg
// Shared types and constants for the AHB master bus-request controller.
//   state_t      : controller FSM states (idle, requesting, owning the bus)
//   HTRANS_*     : AHB transfer-type encodings driven on htrans
//   BEAT_W       : width of the remaining-beat counter (1..16 beats)
//   beats_of()   : converts a beats-minus-one length into a beat count
//   sat_inc4()   : 4-bit saturating increment used for the restart counter
// ---------------------------------------------------------------------------
package ahb_busreq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_OWN  = 2'd2
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam int BEAT_W = 5;

   // A 4-bit length of N means N+1 beats, so the count needs one extra bit.
   function automatic logic [BEAT_W-1:0] beats_of(input logic [3:0] len);
      return {1'b0, len} + 5'd1;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// ---------------------------------------------------------------------------
// ahb_beat_counter
// Tracks how many address beats of the current burst are still outstanding
// and which beat index is in the address phase.
// Ports:
//   hclk, hrst_n : clock, asynchronous active-low reset
//   load         : new burst accepted; load load_len+1 beats, index 0
//   load_len     : burst length, beats minus one
//   start        : bus (re)granted; the next address beat is the first one
//   accept       : current address beat accepted (hready high in OWN)
//   beat_idx     : index of the beat currently in the address phase
//   last         : the beat currently in the address phase is the final one
//   last_next    : after this edge the beat in the address phase is the final one
//   first_next   : after this edge the beat in the address phase follows a
//                  (re)grant and must be issued as NONSEQ
// ---------------------------------------------------------------------------
module ahb_beat_counter
   import ahb_busreq_pkg::*;
(
   input  logic       hclk,
   input  logic       hrst_n,
   input  logic       load,
   input  logic [3:0] load_len,
   input  logic       start,
   input  logic       accept,
   output logic [3:0] beat_idx,
   output logic       last,
   output logic       last_next,
   output logic       first_next
);

   logic [BEAT_W-1:0] remaining_reg, remaining_next;
   logic [3:0]        beat_idx_reg, beat_idx_next;
   logic              first_reg;

   always_comb begin
      remaining_next = remaining_reg;
      beat_idx_next  = beat_idx_reg;
      first_next     = first_reg;
      if (load) begin
         remaining_next = beats_of(load_len);
         beat_idx_next  = 4'd0;
         first_next     = 1'b1;
      end else if (start) begin
         first_next     = 1'b1;
      end else if (accept) begin
         remaining_next = remaining_reg - 5'd1;
         beat_idx_next  = beat_idx_reg + 4'd1;
         first_next     = 1'b0;
      end
   end

   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         remaining_reg <= '0;
         beat_idx_reg  <= 4'd0;
         first_reg     <= 1'b0;
      end else begin
         remaining_reg <= remaining_next;
         beat_idx_reg  <= beat_idx_next;
         first_reg     <= first_next;
      end
   end

   assign beat_idx  = beat_idx_reg;
   assign last      = (remaining_reg == 5'd1);
   assign last_next = (remaining_next == 5'd1);

endmodule

// File: rtl/ahb_master_busreq.sv
// ---------------------------------------------------------------------------
// ahb_master_busreq
// Master-side AHB bus-request controller. Accepts a burst from the local
// engine, requests the bus, issues NONSEQ/SEQ address beats once granted,
// and on grant loss mid-burst re-requests and resumes from the next beat.
// Optional feature macro: BUSREQ_TIMEOUT_EN (request-wait timeout flag).
// Ports:
//   hclk, hrst_n  : AHB clock, asynchronous active-low reset
//   req_valid/len/lock, req_ready : local burst request handshake
//   hgrant, hready, hmaster       : arbiter grant, bus ready, current owner
//   hbusreq, hlock                : request / lock to the arbiter
//   htrans, beat_idx              : address-phase transfer type and beat index
//   data_own                      : this master owns the current data phase
//   xfer_done                     : pulse when the last address beat is accepted
//   restart_cnt                   : saturating grant-loss count for this burst
//   req_timeout                   : sticky request-wait timeout (feature only)
// ---------------------------------------------------------------------------
module ahb_master_busreq
   import ahb_busreq_pkg::*;
#(
   parameter logic [2:0] MASTER_ID      = 3'd0,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic       hclk,
   input  logic       hrst_n,
   input  logic       req_valid,
   input  logic [3:0] req_len,
   input  logic       req_lock,
   output logic       req_ready,
   input  logic       hgrant,
   input  logic       hready,
   input  logic [2:0] hmaster,
   output logic       hbusreq,
   output logic       hlock,
   output logic [1:0] htrans,
   output logic [3:0] beat_idx,
   output logic       data_own,
   output logic       xfer_done,
   output logic [3:0] restart_cnt,
   output logic       req_timeout
);

   state_t     state_reg;
   logic       req_ready_reg;
   logic       hbusreq_reg;
   logic       hlock_reg;
   logic [1:0] htrans_reg;
   logic       data_own_reg;
   logic       xfer_done_reg;
   logic [3:0] restart_cnt_reg;

   logic       accept_req;
   logic       grant_start;
   logic       beat_accept;
   logic       last;
   logic       last_next;
   logic       first_next;

   // req_ready is registered, so a request arriving in the xfer_done cycle
   // (state already IDLE, req_ready still low) waits one more cycle.
   assign accept_req  = (state_reg == ST_IDLE) && req_ready_reg && req_valid;
   assign grant_start = (state_reg == ST_REQ) && hgrant && hready;
   assign beat_accept = (state_reg == ST_OWN) && hready;

   ahb_beat_counter u_beat_counter (
      .hclk       (hclk),
      .hrst_n     (hrst_n),
      .load       (accept_req),
      .load_len   (req_len),
      .start      (grant_start),
      .accept     (beat_accept),
      .beat_idx   (beat_idx),
      .last       (last),
      .last_next  (last_next),
      .first_next (first_next)
   );

   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         state_reg       <= ST_IDLE;
         req_ready_reg   <= 1'b1;
         hbusreq_reg     <= 1'b0;
         hlock_reg       <= 1'b0;
         htrans_reg      <= HTRANS_IDLE;
         data_own_reg    <= 1'b0;
         xfer_done_reg   <= 1'b0;
         restart_cnt_reg <= 4'd0;
      end else begin
         xfer_done_reg <= 1'b0;

         // The beat whose address phase completes on this edge moves into
         // the data phase, so ownership trails the address by one beat.
         if (hready) begin
            data_own_reg <= (hmaster == MASTER_ID) && htrans_reg[1];
         end

         case (state_reg)
            ST_IDLE: begin
               if (!req_ready_reg) begin
                  req_ready_reg <= 1'b1;
               end else if (req_valid) begin
                  req_ready_reg   <= 1'b0;
                  hbusreq_reg     <= 1'b1;
                  hlock_reg       <= req_lock;
                  restart_cnt_reg <= 4'd0;
                  state_reg       <= ST_REQ;
               end
            end

            ST_REQ: begin
               if (hgrant && hready) begin
                  state_reg  <= ST_OWN;
                  htrans_reg <= first_next ? HTRANS_NONSEQ : HTRANS_SEQ;
                  // Single-beat burst: the NONSEQ is also the last address.
                  if (last_next) begin
                     hbusreq_reg <= 1'b0;
                     hlock_reg   <= 1'b0;
                  end
               end
            end

            ST_OWN: begin
               if (hready) begin
                  if (last) begin
                     xfer_done_reg <= 1'b1;
                     htrans_reg    <= HTRANS_IDLE;
                     hbusreq_reg   <= 1'b0;
                     hlock_reg     <= 1'b0;
                     state_reg     <= ST_IDLE;
                  end else if (!last_next && !hgrant) begin
                     // Lost the bus with more than one beat still to go:
                     // park on IDLE and request again; the beat index is kept.
                     htrans_reg      <= HTRANS_IDLE;
                     hbusreq_reg     <= 1'b1;
                     restart_cnt_reg <= sat_inc4(restart_cnt_reg);
                     state_reg       <= ST_REQ;
                  end else begin
                     // A missing grant here only concerns the final beat,
                     // which is allowed to complete.
                     htrans_reg <= first_next ? HTRANS_NONSEQ : HTRANS_SEQ;
                     if (last_next) begin
                        hbusreq_reg <= 1'b0;
                        hlock_reg   <= 1'b0;
                     end
                  end
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_reg;
   assign hbusreq     = hbusreq_reg;
   assign hlock       = hlock_reg;
   assign htrans      = htrans_reg;
   assign data_own    = data_own_reg;
   assign xfer_done   = xfer_done_reg;
   assign restart_cnt = restart_cnt_reg;

`ifdef BUSREQ_TIMEOUT_EN
   logic [7:0] wait_cnt_reg;
   logic       req_timeout_reg;

   // Counts cycles spent waiting for a grant. The flag only reports; the
   // request keeps running. The counter saturates so it never wraps back.
   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         wait_cnt_reg    <= 8'd0;
         req_timeout_reg <= 1'b0;
      end else begin
         if (state_reg == ST_REQ) begin
            if (wait_cnt_reg != 8'hFF) begin
               wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
            if ((int'(wait_cnt_reg) + 1) >= TIMEOUT_CYCLES) begin
               req_timeout_reg <= 1'b1;
            end
         end else begin
            wait_cnt_reg <= 8'd0;
         end
         if (accept_req) begin
            req_timeout_reg <= 1'b0;
         end
      end
   end

   assign req_timeout = req_timeout_reg;
`else
   // Timeout logic not built; keep the parameter referenced so the
   // configuration stays visible in both builds.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign req_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_master_busreq.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_busreq
// Directed bench for ahb_master_busreq (default build, MASTER_ID=0).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_ahb_master_busreq;

   localparam int T_IDLE   = 0;
   localparam int T_NONSEQ = 2;
   localparam int T_SEQ    = 3;

   logic       hclk = 1'b0;
   logic       hrst_n;
   logic       req_valid;
   logic [3:0] req_len;
   logic       req_lock;
   logic       req_ready;
   logic       hgrant;
   logic       hready;
   logic [2:0] hmaster;
   logic       hbusreq;
   logic       hlock;
   logic [1:0] htrans;
   logic [3:0] beat_idx;
   logic       data_own;
   logic       xfer_done;
   logic [3:0] restart_cnt;
   logic       req_timeout;

   int checks = 0;
   int errors = 0;

   ahb_master_busreq dut (
      .hclk        (hclk),
      .hrst_n      (hrst_n),
      .req_valid   (req_valid),
      .req_len     (req_len),
      .req_lock    (req_lock),
      .req_ready   (req_ready),
      .hgrant      (hgrant),
      .hready      (hready),
      .hmaster     (hmaster),
      .hbusreq     (hbusreq),
      .hlock       (hlock),
      .htrans      (htrans),
      .beat_idx    (beat_idx),
      .data_own    (data_own),
      .xfer_done   (xfer_done),
      .restart_cnt (restart_cnt),
      .req_timeout (req_timeout)
   );

   always #5 hclk = ~hclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic expect_bus(input string tag, input int rdy, input int busreq,
                             input int lock, input int trans, input int idx, input int done);
      check_eq({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
      check_eq({tag, ".hbusreq"},   32'(hbusreq),   32'(busreq));
      check_eq({tag, ".hlock"},     32'(hlock),     32'(lock));
      check_eq({tag, ".htrans"},    32'(htrans),    32'(trans));
      check_eq({tag, ".beat_idx"},  32'(beat_idx),  32'(idx));
      check_eq({tag, ".xfer_done"}, 32'(xfer_done), 32'(done));
   endtask

   // Bench-level safety net; the stimulus itself has no open-ended waits.
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int owned;
      int dones;
      int beats;
      int t3_hr[7];
      int t3_tr[7];
      int t3_ix[7];
      int t3_br[7];
      int t4_gr[11];
      int t4_tr[11];
      int t4_ix[11];
      int t4_br[11];
      int t4_rc[11];

      hrst_n    = 1'b0;
      req_valid = 1'b0;
      req_len   = 4'd0;
      req_lock  = 1'b0;
      hgrant    = 1'b0;
      hready    = 1'b1;
      hmaster   = 3'd0;

      // ---------------- reset state ----------------
      tick();
      tick();
      expect_bus("rst", 1, 0, 0, T_IDLE, 0, 0);
      check_eq("rst.restart_cnt", 32'(restart_cnt), 32'd0);
      check_eq("rst.data_own",    32'(data_own),    32'd0);
      check_eq("rst.req_timeout", 32'(req_timeout), 32'd0);
      hrst_n = 1'b1;
      tick();
      expect_bus("idle", 1, 0, 0, T_IDLE, 0, 0);

      // ---------------- single beat, grant after 2 cycles ----------------
      req_valid = 1'b1;
      req_len   = 4'd0;
      tick();
      expect_bus("t1_acc", 0, 1, 0, T_IDLE, 0, 0);
      req_valid = 1'b0;
      tick();
      expect_bus("t1_wait1", 0, 1, 0, T_IDLE, 0, 0);
      tick();
      expect_bus("t1_wait2", 0, 1, 0, T_IDLE, 0, 0);
      hgrant = 1'b1;
      tick();
      expect_bus("t1_nonseq", 0, 0, 0, T_NONSEQ, 0, 0);
      tick();
      expect_bus("t1_done", 0, 0, 0, T_IDLE, 1, 1);
      check_eq("t1_done.data_own", 32'(data_own), 32'd1);
      tick();
      expect_bus("t1_ready", 1, 0, 0, T_IDLE, 1, 0);
      check_eq("t1_ready.data_own", 32'(data_own), 32'd0);
      $display("txn single_beat len=0 checks=%0d errors=%0d", checks, errors);

      // ---------------- 4-beat burst, no wait states ----------------
      req_valid = 1'b1;
      req_len   = 4'd3;
      tick();
      expect_bus("t2_acc", 0, 1, 0, T_IDLE, 0, 0);
      req_valid = 1'b0;
      tick();
      expect_bus("t2_b0", 0, 1, 0, T_NONSEQ, 0, 0);
      tick();
      expect_bus("t2_b1", 0, 1, 0, T_SEQ, 1, 0);
      check_eq("t2_b1.data_own", 32'(data_own), 32'd1);
      tick();
      expect_bus("t2_b2", 0, 1, 0, T_SEQ, 2, 0);
      tick();
      expect_bus("t2_b3", 0, 0, 0, T_SEQ, 3, 0);
      tick();
      expect_bus("t2_done", 0, 0, 0, T_IDLE, 4, 1);
      // Request raised in the xfer_done cycle must not be taken yet.
      req_valid = 1'b1;
      req_len   = 4'd3;
      tick();
      expect_bus("t2_noacc", 1, 0, 0, T_IDLE, 4, 0);
      $display("txn burst4 len=3 checks=%0d errors=%0d", checks, errors);

      // ---------------- 4-beat burst with 2 wait states at beat 1 ----------------
      tick();
      expect_bus("t3_acc", 0, 1, 0, T_IDLE, 0, 0);
      req_valid = 1'b0;
      t3_hr = '{1, 1, 0, 0, 1, 1, 1};
      t3_tr = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE};
      t3_ix = '{0, 1, 1, 1, 2, 3, 4};
      t3_br = '{1, 1, 1, 1, 1, 0, 0};
      owned = 0;
      dones = 0;
      for (int i = 0; i < 7; i++) begin
         hready = t3_hr[i][0];
         tick();
         check_eq($sformatf("t3_c%0d.htrans", i),   32'(htrans),   32'(t3_tr[i]));
         check_eq($sformatf("t3_c%0d.beat_idx", i), 32'(beat_idx), 32'(t3_ix[i]));
         check_eq($sformatf("t3_c%0d.hbusreq", i),  32'(hbusreq),  32'(t3_br[i]));
         if (htrans != 2'b00) owned++;
         if (xfer_done) dones++;
      end
      check_eq("t3.owned_cycles", 32'(owned), 32'd6);
      check_eq("t3.xfer_done_cnt", 32'(dones), 32'd1);
      hready = 1'b1;
      tick();
      expect_bus("t3_ready", 1, 0, 0, T_IDLE, 4, 0);
      $display("txn burst4_wait len=3 checks=%0d errors=%0d", checks, errors);

      // ---------------- 8-beat burst with grant loss after beat 2 ----------------
      req_valid = 1'b1;
      req_len   = 4'd7;
      tick();
      expect_bus("t4_acc", 0, 1, 0, T_IDLE, 0, 0);
      req_valid = 1'b0;
      t4_gr = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
      t4_tr = '{T_NONSEQ, T_SEQ, T_SEQ, T_IDLE, T_IDLE, T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE};
      t4_ix = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7, 8};
      t4_br = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
      t4_rc = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
      beats = 0;
      dones = 0;
      for (int i = 0; i < 11; i++) begin
         hgrant = t4_gr[i][0];
         if (htrans != 2'b00 && hready) beats++;
         tick();
         check_eq($sformatf("t4_c%0d.htrans", i),      32'(htrans),      32'(t4_tr[i]));
         check_eq($sformatf("t4_c%0d.beat_idx", i),    32'(beat_idx),    32'(t4_ix[i]));
         check_eq($sformatf("t4_c%0d.hbusreq", i),     32'(hbusreq),     32'(t4_br[i]));
         check_eq($sformatf("t4_c%0d.restart_cnt", i), 32'(restart_cnt), 32'(t4_rc[i]));
         if (xfer_done) dones++;
      end
      check_eq("t4.beats", 32'(beats), 32'd8);
      check_eq("t4.xfer_done_cnt", 32'(dones), 32'd1);
      tick();
      expect_bus("t4_ready", 1, 0, 0, T_IDLE, 8, 0);
      $display("txn burst8_grant_loss len=7 checks=%0d errors=%0d", checks, errors);

      // ---------------- locked 2-beat burst ----------------
      req_valid = 1'b1;
      req_len   = 4'd1;
      req_lock  = 1'b1;
      tick();
      expect_bus("t5_acc", 0, 1, 1, T_IDLE, 0, 0);
      check_eq("t5_acc.restart_cnt", 32'(restart_cnt), 32'd0);
      req_valid = 1'b0;
      req_lock  = 1'b0;
      tick();
      expect_bus("t5_b0", 0, 1, 1, T_NONSEQ, 0, 0);
      tick();
      expect_bus("t5_b1", 0, 0, 0, T_SEQ, 1, 0);
      tick();
      expect_bus("t5_done", 0, 0, 0, T_IDLE, 2, 1);
      tick();
      expect_bus("t5_ready", 1, 0, 0, T_IDLE, 2, 0);
      $display("txn burst2_locked len=1 checks=%0d errors=%0d", checks, errors);

      // ---------------- locked burst, other owner, reset mid-OWN ----------------
      hmaster   = 3'd3;
      req_valid = 1'b1;
      req_len   = 4'd3;
      req_lock  = 1'b1;
      tick();
      expect_bus("t6_acc", 0, 1, 1, T_IDLE, 0, 0);
      req_valid = 1'b0;
      req_lock  = 1'b0;
      tick();
      expect_bus("t6_b0", 0, 1, 1, T_NONSEQ, 0, 0);
      tick();
      expect_bus("t6_b1", 0, 1, 1, T_SEQ, 1, 0);
      check_eq("t6_b1.data_own", 32'(data_own), 32'd0);
      hrst_n = 1'b0;
      #1;
      expect_bus("t6_rst", 1, 0, 0, T_IDLE, 0, 0);
      check_eq("t6_rst.restart_cnt", 32'(restart_cnt), 32'd0);
      check_eq("t6_rst.data_own",    32'(data_own),    32'd0);
      tick();
      hrst_n = 1'b1;
      tick();
      expect_bus("t6_idle", 1, 0, 0, T_IDLE, 0, 0);
      $display("txn burst4_reset len=3 checks=%0d errors=%0d", checks, errors);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
